// File: rtl/div_signed_seq_if.sv
// Request/result bundle between the E100 sequencer (master) and the signed divider (slave).
// The remainder signal exists only when DIV_REM_EN is defined.
interface div_signed_seq_if #(parameter int WIDTH = 32);
   // Handshake: the sequencer raises start while busy=0; the divider accepts it on that
   // clock edge, holds busy=1 until results are ready, then pulses done for one cycle.
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
`ifdef DIV_REM_EN
   logic [WIDTH-1:0] remainder;
`endif
   logic             div0;

   modport master (
      output start, in1, in2,
`ifdef DIV_REM_EN
      input  remainder,
`endif
      input  busy, done, quotient, div0
   );

   modport slave (
      input  start, in1, in2,
`ifdef DIV_REM_EN
      output remainder,
`endif
      output busy, done, quotient, div0
   );
endinterface

// File: rtl/div_signed_seq.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per cycle,
// then a sign fix-up. Optional remainder output enabled by DIV_REM_EN.
module div_signed_seq #(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   div_signed_seq_if.slave   bus,
   output logic [1:0]        fsm_state
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    counter;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             sign1, sign2, zdiv;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH:0]   shifted, trial;

   // Magnitudes wrap for the most negative value, which is then read as unsigned 2^(WIDTH-1).
   always_comb begin
      mag1    = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
      mag2    = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
      shifted = {prem[WIDTH-1:0], dvd[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = (bus.in2 == '0) ? FIXUP : RUN;
         RUN:     if (counter == CW'(WIDTH - 1)) state_nx = FIXUP;
         FIXUP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   assign bus.busy  = (state != IDLE);
   assign fsm_state = state;

   // The dividend register doubles as the quotient shift register during RUN.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         counter      <= '0;
         prem         <= '0;
         dvd          <= '0;
         dvs          <= '0;
         sign1        <= 1'b0;
         sign2        <= 1'b0;
         zdiv         <= 1'b0;
         bus.done     <= 1'b0;
         bus.div0     <= 1'b0;
         bus.quotient <= '0;
`ifdef DIV_REM_EN
         bus.remainder <= '0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dvd     <= mag1;
                  dvs     <= mag2;
                  sign1   <= bus.in1[WIDTH-1];
                  sign2   <= bus.in2[WIDTH-1];
                  zdiv    <= (bus.in2 == '0);
                  prem    <= '0;
                  counter <= '0;
               end
            end
            RUN: begin
               prem    <= trial[WIDTH] ? shifted : trial;
               dvd     <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
               counter <= counter + 1'b1;
            end
            FIXUP: begin
               bus.done <= 1'b1;
               if (zdiv) begin
                  bus.quotient <= '1;
                  bus.div0     <= 1'b1;
`ifdef DIV_REM_EN
                  // Rebuild the original dividend from its latched magnitude and sign.
                  bus.remainder <= sign1 ? -dvd : dvd;
`endif
               end else begin
                  bus.quotient <= (sign1 ^ sign2) ? -dvd : dvd;
                  bus.div0     <= 1'b0;
`ifdef DIV_REM_EN
                  bus.remainder <= sign1 ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule
